// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, line idles high.
// The asynchronous serial input is double-flopped and then sampled on baud
// ticks produced at BAUD_RATE*OVERSAMPLING by a fractional phase accumulator,
// so non-integer clock/tick ratios hold the correct average bit period.
// Each good byte is delivered with a one-cycle o_rx_valid pulse. A low stop
// bit gives a one-cycle o_frame_err pulse instead, and o_rx_data is left alone.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit between the
// data and stop bits and drives o_parity_err. Without it o_parity_err is tied low.
module uart_rx #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLING = 16
) (
  input  logic       i_clk,
  input  logic       i_aresetn,
  input  logic       i_rx_data,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam int TW = $clog2(OVERSAMPLING);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLING / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLING - 1);

  // The tick rate is computed in 64 bits so it cannot overflow, then cut down
  // to the accumulator width.
  localparam longint unsigned TICK_RATE = longint'(BAUD_RATE) * longint'(OVERSAMPLING);
  localparam logic [33:0] ACC_INC = 34'(TICK_RATE);
  localparam logic [33:0] ACC_MOD = 34'(CLK_FREQ);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic [33:0]   acc;
  logic [33:0]   acc_sum;
  logic          baud_tick;
  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shifter;
`ifdef UART_RX_PARITY_EN
  logic          parity_bit;
  logic          parity_err_q;
`endif

  assign acc_sum = acc + ACC_INC;

  // Baud tick generator: one-cycle tick each time the phase accumulator wraps.
  // NOTE: every sequential block uses non-blocking (<=) assignments, so all
  // flops update together from the values they held before the clock edge.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      acc       <= '0;
      baud_tick <= 1'b0;
    end else if (acc_sum >= ACC_MOD) begin
      acc       <= acc_sum - ACC_MOD;
      baud_tick <= 1'b1;
    end else begin
      acc       <= acc_sum;
      baud_tick <= 1'b0;
    end
  end

  // Two-flop synchronizer. It resets to the idle-high line level so that
  // leaving reset can never look like a start bit.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx_data;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with registered output pulses. Every state decision is made
  // on a baud tick, using the synchronized line value.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      // NOTE: the shifter is a plain register, not a memory, so resetting it
      // costs nothing and keeps its contents known after reset.
      shifter      <= '0;
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Pulses default low and are raised only in the cycle they apply to.
      o_rx_valid   <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              tick_cnt <= '0;
              state    <= START;
            end
          end
          START: begin
            if (tick_cnt == MID) begin
              if (!rx_s) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                state    <= DATA;
              end else begin
                // The line went high again before mid-bit, so this was a glitch.
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == LAST) begin
              shifter  <= {rx_s, shifter[7:1]};
              tick_cnt <= '0;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == LAST) begin
              parity_bit <= rx_s;
              tick_cnt   <= '0;
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                o_rx_data  <= shifter;
                o_rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= ^{shifter, parity_bit};
`endif
                // Returning to IDLE at the stop-bit centre lets a start bit
                // that follows straight after be caught without losing a frame.
                state <= IDLE;
              end else begin
                o_frame_err <= 1'b1;
                state       <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          BREAK: begin
            // A line held low is never taken as a new start bit.
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx.
// The baud rate is raised to 1 Mbaud at 100 MHz so the run stays short. That
// gives 100 clocks per bit and 6.25 clocks per tick, which still exercises the
// fractional tick generator. The stimulus tasks push the expected response
// of each frame into a queue, and an independent monitor pops an entry and
// compares it whenever the DUT raises a pulse.
module tb_uart_rx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int OS       = 16;
  localparam int BIT      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic       valid;
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic       clk     = 1'b0;
  logic       aresetn = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;

  int         n_cmp = 0;
  int         n_err = 0;
  longint     cyc = 0;
  exp_t       sb[$];
  longint     valid_cyc[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD),
    .OVERSAMPLING(OS)
  ) dut (
    .i_clk       (clk),
    .i_aresetn   (aresetn),
    .i_rx_data   (rx),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .o_frame_err (frame_err),
    .o_parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT) @(posedge clk);
  endtask

  // Reference model: a frame with a good stop bit delivers its byte. With
  // parity, a flipped parity bit also raises the parity flag. A frame with a
  // bad stop bit raises only the framing flag and leaves the last good byte.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip);
    exp_t e;
    if (stop_ok) begin
      last_good = d;
      e = '{valid: 1'b1, ferr: 1'b0, data: d, perr: PAR_EN & par_flip};
    end else begin
      e = '{valid: 1'b0, ferr: 1'b1, data: last_good, perr: 1'b0};
    end
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ par_flip);
    drive_bit(stop_ok);
  endtask

  // Monitor: every DUT pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (aresetn) begin
      if (parity_err && !rx_valid) check("parity_without_valid", {31'b0, rx_valid}, 32'd1);
      if (rx_valid || frame_err) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'b0, rx_valid, frame_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rx_valid",   {31'b0, rx_valid},   {31'b0, e.valid});
          check("frame_err",  {31'b0, frame_err},  {31'b0, e.ferr});
          check("rx_data",    {24'b0, rx_data},    {24'b0, e.data});
          check("parity_err", {31'b0, parity_err}, {31'b0, e.perr});
          if (rx_valid) valid_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int     n0;
    longint gap;
    logic [7:0] d;
    bit     stop_ok;
    bit     flip;

    // Reset values.
    aresetn = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data",    {24'b0, rx_data},  32'd0);
    check("reset_rx_valid",   {31'b0, rx_valid}, 32'd0);
    check("reset_frame_err",  {31'b0, frame_err}, 32'd0);
    check("reset_parity_err", {31'b0, parity_err}, 32'd0);
    aresetn = 1'b1;
    idle_bits(2);

    // A single good frame.
    send_frame(8'h55, 1'b1, 1'b0);
    idle_bits(2);

    // Two frames back to back, each with a single stop bit.
    n0 = valid_cyc.size();
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle_bits(2);
    check("b2b_count", valid_cyc.size() - n0, 32'd2);
    if (valid_cyc.size() >= n0 + 2) begin
      gap = valid_cyc[n0 + 1] - valid_cyc[n0];
      check("b2b_spacing_in_window",
            {31'b0, (gap >= (PAR_EN ? 11 : 10) * BIT - 20) && (gap <= (PAR_EN ? 11 : 10) * BIT + 20)},
            32'd1);
    end

    // A short low glitch must be rejected, and the next frame must still arrive.
    rx = 1'b0;
    repeat (BIT * 35 / 100) @(posedge clk);
    idle_bits(3);
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(2);

    // Bad stop bit, then the line held low (break), then a recovery frame.
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (20 * BIT) @(posedge clk);
    idle_bits(2);
    send_frame(8'hC5, 1'b1, 1'b0);
    idle_bits(2);

    // Reset in the middle of data bit 4 of 0xFF discards the frame.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (BIT / 2) @(posedge clk);
    aresetn = 1'b0;
    #1;
    check("midreset_rx_data",    {24'b0, rx_data},   32'd0);
    check("midreset_rx_valid",   {31'b0, rx_valid},  32'd0);
    check("midreset_frame_err",  {31'b0, frame_err}, 32'd0);
    check("midreset_parity_err", {31'b0, parity_err}, 32'd0);
    last_good = 8'h00;
    repeat (5) @(posedge clk);
    aresetn = 1'b1;
    idle_bits(2);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle_bits(2);

    // Parity: a correct parity bit first, then a wrong one.
    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b0);
      idle_bits(1);
      send_frame(8'h07, 1'b1, 1'b1);
      idle_bits(2);
    end

    // Random traffic: mostly good frames, with occasional framing errors and
    // parity flips.
    for (int k = 0; k < 16; k++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
      flip    = 1'($urandom_range(0, 1));
      send_frame(d, stop_ok, flip);
      if (!stop_ok) begin
        repeat ($urandom_range(BIT, 3 * BIT)) @(posedge clk);
        idle_bits(1);
      end
      rx = 1'b1;
      repeat ($urandom_range(0, 2 * BIT)) @(posedge clk);
    end

    idle_bits(3);
    @(negedge clk);
    check("pending_expected", sb.size(), 32'd0);
    check("held_rx_data", {24'b0, rx_data}, {24'b0, last_good});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; counterpart of the existing UART_TX on the same serial link (8N1, LSB first, line idles high).
- Oversamples the asynchronous serial input using the team's BaudTickGen at BAUD_RATE*OVERSAMPLING.
- Delivers each received byte with a one-cycle valid pulse and flags framing errors.
- Sits between the external RX pin and the byte-level consumer.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- OVERSAMPLING, 16, ticks per bit; power of 2, at least 8; tick counter width = $clog2(OVERSAMPLING).

Ports:
- i_clk  input  1  system clock
- i_aresetn  input  1  asynchronous active-low reset
- i_rx_data  input  1  serial line, asynchronous to i_clk
- o_rx_data  output  8  last good received byte; held until the next good byte
- o_rx_valid  output  1  one-cycle pulse: o_rx_data updated this cycle
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low
- o_parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Reset: i_aresetn is asynchronous and active-low; clock is i_clk.
  - All outputs reset to 0.
  - Synchronizer flops reset to 1.
  - FSM goes to IDLE; tick counter and bit counter reset to 0.
- Input path: 2-FF synchronizer on i_rx_data. All decisions use the synchronized value (rx_s), sampled only on cycles where baud_tick=1.
- Let MID = OVERSAMPLING/2-1 and LAST = OVERSAMPLING-1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on a tick with rx_s=0, clear tick_cnt and go to START.
  - START: on each tick, increment tick_cnt. At tick_cnt==MID:
    - rx_s=0: clear tick_cnt and bit_cnt, go to DATA.
    - rx_s=1: glitch; go to IDLE with no output activity.
  - DATA: on each tick, increment tick_cnt. At tick_cnt==LAST (bit centre):
    - Shift rx_s into shifter MSB (right shift), clear tick_cnt.
    - If bit_cnt==7, go to STOP; otherwise increment bit_cnt.
  - STOP: at tick_cnt==LAST:
    - rx_s=1: o_rx_data <= shifter, o_rx_valid pulse, go to IDLE.
    - rx_s=0: o_frame_err pulse, o_rx_data unchanged, go to BREAK.
  - BREAK: stay until a tick with rx_s=1, then go to IDLE. A held-low line is never treated as a new start.
  - Unused state encodings return to IDLE.
- Latency:
  - Output pulses are registered and assert the clock after the stop-sample tick.
  - End-to-end delay from line edge to valid is about 9.5 bit times plus 2 sync cycles plus 1 cycle.
- Back-to-back frames: returning to IDLE at the stop-bit centre allows a start bit that immediately follows the stop bit to be caught with no lost frame.
- Only one of o_rx_valid and o_frame_err can pulse per frame.
- Reset mid-frame: the partial byte is discarded, no pulse is produced, and reception restarts at IDLE.
- No flow control: a new byte overwrites o_rx_data whether or not the consumer has taken the previous one.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - Parity bit sampled at tick_cnt==LAST; even parity over the 8 data bits plus the parity bit.
  - On mismatch, o_parity_err pulses in the same cycle as o_rx_valid (the byte is still delivered), provided the stop bit is good.
  - If the stop bit is bad, only o_frame_err pulses.
- Undefined:
  - No PARITY state; o_parity_err is tied to 0.

Test Plan (CLK_FREQ=100 MHz, BAUD=115200, OVERSAMPLING=16, bit period 868 clocks):
- Single frame 0x55 with a good stop bit -> exactly one o_rx_valid pulse, o_rx_data=0x55, o_frame_err=0 throughout.
- Frames 0xA3 then 0x0F back-to-back with one stop bit -> two valid pulses in order, data 0xA3 then 0x0F, about 10 bit times apart.
- Line pulled low for 300 clocks then high -> no pulses; FSM back in IDLE; next frame 0x81 received correctly.
- Frame 0x00 with stop bit low, line held low for 20 bit times, then high, then frame 0xC5 -> one o_frame_err pulse, o_rx_data keeps its prior value; no activity during the low period; then valid with 0xC5.
- i_aresetn asserted during data bit 4 of 0xFF -> all outputs 0 immediately, no pulse; following frame 0x3C -> valid with 0x3C.
- With UART_RX_PARITY_EN:
  - 0x07 with parity bit 1 -> valid, o_parity_err=0.
  - 0x07 with parity bit 0 -> valid with 0x07 and o_parity_err pulse in the same cycle.
